// File: rtl/junction_phase_arbiter.sv
// Four-approach junction phase scheduler: round-robin right-of-way with
// min/max green, fixed yellow and all-red clearance, and an emergency preempt.
module junction_phase_arbiter #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_id,
  output logic [7:0] light,
  output logic [1:0] active,
  output logic [1:0] phase,
  output logic       grant_start
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GMIN   = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX   = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       active_reg, active_next;
  logic [1:0]       last_reg, last_next;
  logic [7:0]       light_reg, light_next;
  logic             grant_reg;
  logic [1:0]       lamp_next;

  logic [1:0] cand [4];
  logic       rr_found;
  logic [1:0] rr_winner;
  logic       arb_valid;
  logic [1:0] arb_winner;
  logic       arb_eval;
  logic       other_req;
  logic       own_req;
  logic       green_exit;

  // cand[k] is the k-th approach visited when searching after the last winner
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_reg + 2'(gi + 1);
    end
  endgenerate

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_reg;
    for (int i = 3; i >= 0; i--) begin
      if (req[cand[i]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[i];
      end
    end
  end

  assign arb_valid  = preempt | rr_found;
  assign arb_winner = preempt ? preempt_id : rr_winner;
  assign other_req  = |(req & ~(4'b0001 << active_reg));
  assign own_req    = req[active_reg];

  // Preempt either pins the current green or cuts it short, never both
  always_comb begin
    if (preempt) begin
      green_exit = (preempt_id != active_reg);
    end else begin
      green_exit = other_req && (cnt_reg >= GMIN) && (!own_req || (cnt_reg >= GMAX));
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    active_next = active_reg;
    last_next   = last_reg;
    arb_eval    = 1'b0;
    case (state_reg)
      ST_ALLRED: begin
        if (cnt_reg >= R_LAST) arb_eval = 1'b1;
        else                   cnt_next = cnt_reg + CNT_ONE;
      end
      ST_IDLE: arb_eval = 1'b1;
      ST_GREEN: begin
        if (green_exit) begin
          state_next = ST_YELLOW;
          cnt_next   = '0;
        end else if (cnt_reg < GMAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_YELLOW: begin
        if (cnt_reg >= Y_LAST) begin
          state_next = ST_ALLRED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = ST_ALLRED;
    endcase
    if (arb_eval) begin
      if (arb_valid) begin
        state_next  = ST_GREEN;
        cnt_next    = CNT_ONE;
        active_next = arb_winner;
        last_next   = arb_winner;
      end else begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end
  end

  always_comb begin
    case (state_next)
      ST_GREEN:  lamp_next = 2'd2;
      ST_YELLOW: lamp_next = 2'd1;
      default:   lamp_next = 2'd0;
    endcase
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_light
      assign light_next[2*gi +: 2] = (active_next == 2'(gi)) ? lamp_next : 2'd0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg  <= ST_ALLRED;
      cnt_reg    <= '0;
      active_reg <= 2'd0;
      last_reg   <= 2'd3;
      light_reg  <= 8'h00;
      grant_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      active_reg <= active_next;
      last_reg   <= last_next;
      light_reg  <= light_next;
      grant_reg  <= (state_next == ST_GREEN) && (state_reg != ST_GREEN);
    end
  end

  assign light       = light_reg;
  assign active      = active_reg;
  assign phase       = state_reg;
  assign grant_start = grant_reg;

endmodule

// File: doc/junction_phase_arbiter.md
# junction_phase_arbiter

Four-approach intersection phase scheduler. Shares a single right-of-way between four approach requesters (car detectors) with round-robin fairness, min/max green timing, fixed yellow and all-red clearance intervals, and one emergency preempt input. It sits above the per-road signal heads and drives all four lights directly, generalising the highway/country controller to a full junction.

## Interface
Parameters:
- GREEN_MIN, 4: minimum green length in cycles (≥1).
- GREEN_MAX, 12: green length after which a contested green is forced off (≥ GREEN_MIN).
- YELLOW_T, 3: yellow length in cycles (≥1).
- ALLRED_T, 2: all-red clearance length in cycles (≥1).
- CNT_W, 4: phase counter width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T).

Ports:
- clock  in  1  single clock; all state changes on posedge.
- clear_n  in  1  reset, synchronous, active-low.
- req  in  4  per-approach demand; bit i = approach i (0=N, 1=E, 2=S, 3=W); level-sensitive.
- preempt  in  1  emergency preempt request, level-sensitive.
- preempt_id  in  2  approach to be served by preempt; sampled while preempt high.
- light  out  8  light[2i+1:2i] = approach i; RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- active  out  2  approach currently holding (or last held) right-of-way.
- phase  out  2  IDLE=0, GREEN=1, YELLOW=2, ALLRED=3.
- grant_start  out  1  one-cycle pulse in the first GREEN cycle of every grant.

## Operation
- Moore FSM; light, phase, active decoded from registered state only. Non-active approaches always RED.
- States:
  - ALLRED: all lights RED; exactly ALLRED_T cycles, then arbitrate: any req or preempt → GREEN for winner; none → IDLE.
  - IDLE: all RED; each cycle arbitrate; on winner → GREEN next cycle.
  - GREEN: active approach GREEN; counter cnt = 1 in first GREEN cycle, increments each cycle, saturates at GREEN_MAX.
  - YELLOW: active approach YELLOW; exactly YELLOW_T cycles, then ALLRED.
- GREEN exit, evaluated at the edge ending GREEN cycle cnt, with other = OR of req bits except active:
  - exit if other && cnt ≥ GREEN_MIN && (!req[active] || cnt ≥ GREEN_MAX).
  - no other request: stay GREEN indefinitely (rest on green), regardless of own req.
- Arbitration: round-robin search starting at (last+1) mod 4; first set req bit wins; last ← winner. Reset sets last = 3 (approach 0 highest priority first).
- Preempt (overrides round-robin):
  - GREEN, active == preempt_id: hold GREEN, ignore GREEN_MAX and other requests.
  - GREEN, active ≠ preempt_id: go YELLOW at next edge, ignoring GREEN_MIN.
  - YELLOW / ALLRED: intervals run to completion (never shortened).
  - Arbitration point (end of ALLRED, or IDLE): winner = preempt_id even if its req bit is low; last ← preempt_id.
- req or preempt changes during YELLOW/ALLRED have no effect until the arbitration point.

## Timing
- Reset (clear_n low at an edge): state ALLRED, cnt cleared, last = 3; light = 8'h00, phase = 3, active = 0, grant_start = 0. Reset mid-phase aborts immediately; no yellow is shown.
- After clear_n rises: ALLRED_T all-red cycles, then arbitration.
- IDLE → GREEN latency: req sampled at edge k, GREEN visible from edge k.
- A full handover: GREEN (≥ GREEN_MIN) → YELLOW_T → ALLRED_T → next GREEN; minimum turnaround between two greens = YELLOW_T + ALLRED_T cycles.
- grant_start asserted exactly in the cycle phase first reads GREEN for a grant.
- Counter compares are unsigned, CNT_W bits; no wrap (saturating).

## Test plan
- Reset: clear_n low 3 cycles, req=0 → light=8'h00, phase=3 for 2 cycles after release, then phase=0 indefinitely.
- req=4'b0100 held → after ALLRED, light=8'h20, active=2, grant_start one pulse; stays GREEN indefinitely.
- req=4'b0011 held from reset → approach 0 GREEN (8'h02) exactly 12 cycles, 8'h01 for 3, 8'h00 for 2, then approach 1 GREEN (8'h08) 12 cycles; alternates.
- req[1] held; req[3] raised at GREEN cycle 2 and req[1] dropped → approach 1 GREEN ends after cycle 4 (GREEN_MIN), then YELLOW 3, ALLRED 2, approach 3 GREEN (8'h80).
- Approach 0 GREEN cycle 1, preempt=1, preempt_id=3, req[1] pending → YELLOW next cycle, ALLRED 2, approach 3 GREEN held while preempt high despite req[1].
- clear_n low during YELLOW of approach 2 → next cycle light=8'h00, phase=3; after release req=4'b0101 → approach 0 granted first.
